// File: rtl/game_pkg.sv
// Shared encodings for the game-state FSM, the chart ROM entry layout
// and the chart sequencer state machine.
package game_pkg;

  typedef enum logic [1:0] {
    GS_START  = 2'd0,
    GS_MENU   = 2'd1,
    GS_PLAY   = 2'd2,
    GS_FINISH = 2'd3
  } game_state_e;

  localparam int END_BIT  = 7;
  localparam int LANE_MSB = 6;
  localparam int LANE_LSB = 4;
  localparam int REST_MSB = 3;
  localparam int REST_LSB = 0;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_FETCH,
    SEQ_ISSUE,
    SEQ_WAIT,
    SEQ_DONE
  } seq_state_e;

  function automatic logic [2:0] entry_lanes(input logic [7:0] entry);
    return entry[LANE_MSB:LANE_LSB];
  endfunction

  function automatic logic [3:0] entry_rest(input logic [7:0] entry);
    return entry[REST_MSB:REST_LSB];
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Beat timebase: divides clk into ticks, and ticks into beats; beat_pulse is
// high for the single enabled cycle that completes a beat.
module tick_divider #(
  parameter int TICK_DIV   = 25000,
  parameter int BEAT_TICKS = 250
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic beat_pulse
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_TICKS - 1);

  logic [TW-1:0] r_tick_cnt;
  logic [BW-1:0] r_beat_cnt;
  logic          w_tick;

  assign w_tick     = en && (r_tick_cnt == TICK_LAST);
  assign beat_pulse = w_tick && (r_beat_cnt == BEAT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
      r_beat_cnt <= '0;
    end else if (clr) begin
      r_tick_cnt <= '0;
      r_beat_cnt <= '0;
    end else if (en) begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
      if (w_tick) r_beat_cnt <= (r_beat_cnt == BEAT_LAST) ? '0 : r_beat_cnt + BW'(1);
    end
  end

endmodule

// File: rtl/chart_sequencer.sv
// Note-chart playback sequencer: fetches chart entries over req/ack, issues
// lane spawns and paces steps in beats. Optional CHART_PAUSE_EN adds a pause input.
module chart_sequencer
  import game_pkg::*;
#(
  parameter int TICK_DIV   = 25000,
  parameter int BEAT_TICKS = 250,
  parameter int ADDR_W     = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        state,
  input  logic [1:0]        song_sel,
`ifdef CHART_PAUSE_EN
  input  logic              pause,
`endif
  output logic              rom_req,
  output logic [ADDR_W+1:0] rom_addr,
  input  logic              rom_ack,
  input  logic [7:0]        rom_data,
  output logic              spawn_valid,
  output logic [2:0]        spawn_lanes,
  input  logic              spawn_ready,
  output logic              finish,
  output logic [ADDR_W-1:0] step_idx,
  output logic              busy
);

  seq_state_e        r_fsm;
  logic [1:0]        r_state_q;
  logic [1:0]        r_song;
  logic [ADDR_W-1:0] r_step;
  logic [3:0]        r_rest;
  logic [3:0]        r_beat_cnt;
  logic              r_rom_req;
  logic              r_spawn_valid;
  logic [2:0]        r_spawn_lanes;
  logic              r_finish;

  logic w_pause;
  logic w_in_play;
  logic w_play_start;
  logic w_beat_pulse;
  logic w_tick_clr;
  logic w_tick_en;

`ifdef CHART_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  assign w_in_play    = (state == GS_PLAY);
  assign w_play_start = w_in_play && (r_state_q != GS_PLAY);

  // Holding the divider in clear outside WAIT makes every WAIT start from zero.
  assign w_tick_clr = (r_fsm != SEQ_WAIT);
  assign w_tick_en  = (r_fsm == SEQ_WAIT) && !w_pause;

  tick_divider #(
    .TICK_DIV  (TICK_DIV),
    .BEAT_TICKS(BEAT_TICKS)
  ) u_tick_divider (
    .clk       (clk),
    .rst       (rst),
    .clr       (w_tick_clr),
    .en        (w_tick_en),
    .beat_pulse(w_beat_pulse)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm         <= SEQ_IDLE;
      r_state_q     <= '0;
      r_song        <= '0;
      r_step        <= '0;
      r_rest        <= '0;
      r_beat_cnt    <= '0;
      r_rom_req     <= 1'b0;
      r_spawn_valid <= 1'b0;
      r_spawn_lanes <= '0;
      r_finish      <= 1'b0;
    end else begin
      r_state_q <= state;
      case (r_fsm)
        SEQ_IDLE: begin
          if (w_play_start) begin
            r_song     <= song_sel;
            r_step     <= '0;
            r_beat_cnt <= '0;
            if (song_sel == 2'd0) begin
              r_fsm    <= SEQ_DONE;
              r_finish <= 1'b1;
            end else begin
              r_fsm     <= SEQ_FETCH;
              r_rom_req <= !w_pause;
            end
          end
        end
        SEQ_FETCH: begin
          if (!w_in_play) begin
            r_fsm     <= SEQ_IDLE;
            r_rom_req <= 1'b0;
          end else if (r_rom_req && rom_ack) begin
            r_rom_req  <= 1'b0;
            r_rest     <= entry_rest(rom_data);
            r_beat_cnt <= '0;
            if (rom_data[END_BIT]) begin
              r_fsm    <= SEQ_DONE;
              r_finish <= 1'b1;
            end else if (entry_lanes(rom_data) == 3'b000) begin
              r_fsm <= SEQ_WAIT;
            end else begin
              r_fsm         <= SEQ_ISSUE;
              r_spawn_valid <= 1'b1;
              r_spawn_lanes <= entry_lanes(rom_data);
            end
          end else if (!r_rom_req && !w_pause) begin
            r_rom_req <= 1'b1;
          end
        end
        SEQ_ISSUE: begin
          if (!w_in_play) begin
            r_fsm         <= SEQ_IDLE;
            r_spawn_valid <= 1'b0;
          end else if (spawn_ready) begin
            r_fsm         <= SEQ_WAIT;
            r_spawn_valid <= 1'b0;
          end
        end
        SEQ_WAIT: begin
          if (!w_in_play) begin
            r_fsm <= SEQ_IDLE;
          end else if (w_beat_pulse) begin
            if (r_beat_cnt == r_rest) begin
              if (r_step == '1) begin
                r_fsm    <= SEQ_DONE;
                r_finish <= 1'b1;
              end else begin
                r_step    <= r_step + ADDR_W'(1);
                r_fsm     <= SEQ_FETCH;
                r_rom_req <= !w_pause;
              end
            end else begin
              r_beat_cnt <= r_beat_cnt + 4'd1;
            end
          end
        end
        SEQ_DONE: begin
          if (!w_in_play) begin
            r_fsm    <= SEQ_IDLE;
            r_finish <= 1'b0;
          end
        end
        default: r_fsm <= SEQ_IDLE;
      endcase
    end
  end

  assign rom_req     = r_rom_req;
  assign rom_addr    = {r_song, r_step};
  assign spawn_valid = r_spawn_valid;
  assign spawn_lanes = r_spawn_lanes;
  assign finish      = r_finish;
  assign step_idx    = r_step;
  assign busy        = (r_fsm != SEQ_IDLE);

endmodule

// File: tb/tb_chart_sequencer.sv
// Self-checking bench for chart_sequencer with a behavioural chart-playback
// model; the pause scenario is built only when CHART_PAUSE_EN is defined.
module tb_chart_sequencer;

  localparam int TICK_DIV   = 4;
  localparam int BEAT_TICKS = 2;
  localparam int ADDR_W     = 6;
  localparam int BEAT_CYC   = TICK_DIV * BEAT_TICKS;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        state;
  logic [1:0]        song_sel;
  logic              rom_req;
  logic [ADDR_W+1:0] rom_addr;
  logic              rom_ack;
  logic [7:0]        rom_data;
  logic              spawn_valid;
  logic [2:0]        spawn_lanes;
  logic              spawn_ready;
  logic              finish;
  logic [ADDR_W-1:0] step_idx;
  logic              busy;
`ifdef CHART_PAUSE_EN
  logic              pause = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rom_mem [256];
  bit rom_auto = 1'b0;
  int rom_lat  = 2;
  bit rdy_rand = 1'b0;
  bit rdy_val  = 1'b1;

  // observed playback
  bit         mon_en = 1'b1;
  logic [7:0] q_fetch [$];
  logic [2:0] q_spawn [$];
  int         q_wait  [$];
  int         wait_run, req_starts, stab_viol;
  bit         fin_seen;

  // expected playback
  logic [7:0] exp_fetch [$];
  logic [2:0] exp_spawn [$];
  int         exp_wait  [$];
  int         exp_last;

  always #5 clk = ~clk;

  chart_sequencer #(
    .TICK_DIV  (TICK_DIV),
    .BEAT_TICKS(BEAT_TICKS),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .state      (state),
    .song_sel   (song_sel),
    .rom_req    (rom_req),
    .rom_addr   (rom_addr),
    .rom_ack    (rom_ack),
    .rom_data   (rom_data),
    .spawn_valid(spawn_valid),
    .spawn_lanes(spawn_lanes),
    .spawn_ready(spawn_ready),
    .finish     (finish),
    .step_idx   (step_idx),
    .busy       (busy)
`ifdef CHART_PAUSE_EN
    , .pause    (pause)
`endif
  );

  // ROM: acknowledges a pending request after rom_lat cycles, one-cycle ack
  initial begin
    int cnt = 0;
    rom_ack  = 1'b0;
    rom_data = '0;
    forever begin
      @(posedge clk); #1;
      if (rom_ack) begin
        rom_ack = 1'b0;
        cnt = 0;
      end else if (rom_auto && rom_req) begin
        cnt++;
        if (cnt >= rom_lat) begin
          rom_ack  = 1'b1;
          rom_data = rom_mem[rom_addr];
        end
      end else cnt = 0;
    end
  end

  initial begin
    spawn_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      spawn_ready = rdy_rand ? 1'($urandom) : rdy_val;
    end
  end

  // Monitor: records fetches, spawn transfers and WAIT run lengths
  initial begin
    logic       p_valid, p_ready, p_req;
    logic [2:0] p_lanes;
    p_valid = 0; p_ready = 0; p_req = 0; p_lanes = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rom_req && !p_req) req_starts++;
        if (rom_req && rom_ack) q_fetch.push_back(rom_addr);
        if (spawn_valid && spawn_ready) q_spawn.push_back(spawn_lanes);
        if (p_valid && !p_ready && (spawn_valid !== 1'b1 || spawn_lanes !== p_lanes)) stab_viol++;
        if (finish) fin_seen = 1'b1;
        if (busy && !rom_req && !spawn_valid && !finish) wait_run++;
        else if (wait_run > 0) begin
          q_wait.push_back(wait_run);
          wait_run = 0;
        end
      end
      p_valid = spawn_valid; p_ready = spawn_ready; p_req = rom_req; p_lanes = spawn_lanes;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1);
  end

  task automatic clear_mon();
    q_fetch.delete(); q_spawn.delete(); q_wait.delete();
    wait_run = 0; req_starts = 0; stab_viol = 0; fin_seen = 1'b0;
  endtask

  // Reference: walk the chart entry by entry from step 0
  task automatic model_song(input logic [1:0] s);
    logic [7:0] e;
    exp_fetch.delete(); exp_spawn.delete(); exp_wait.delete();
    exp_last = 0;
    for (int st = 0; st < 64; st++) begin
      e = rom_mem[{s, 6'(st)}];
      exp_fetch.push_back({s, 6'(st)});
      exp_last = st;
      if (e[7]) break;
      if (e[6:4] != 3'b000) exp_spawn.push_back(e[6:4]);
      exp_wait.push_back((int'(e[3:0]) + 1) * BEAT_CYC);
    end
  endtask

  task automatic play_song(input logic [1:0] s, input int budget, input bit scramble, output bit ok);
    clear_mon();
    song_sel = s;
    @(posedge clk); #1;
    state = 2'd2;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (scramble && i == 3) song_sel = 2'($urandom);
      if (finish) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic end_play();
    state = 2'd3;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; state = 2'd0; song_sel = 2'd0; rom_auto = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({rom_req, rom_addr, spawn_valid, spawn_lanes, finish, step_idx, busy} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got req=%b addr=%h sv=%b sl=%b fin=%b step=%0d busy=%b required all 0",
                         rom_req, rom_addr, spawn_valid, spawn_lanes, finish, step_idx, busy);
    end
    rst = 1'b0; state = 2'd1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({rom_req, finish, busy, spawn_valid} !== 4'b0) begin
      n_fail++; $display("FAIL idle_after_release got req=%b fin=%b busy=%b sv=%b required 0", rom_req, finish, busy, spawn_valid);
    end
    rom_mem[8'h80] = 8'h10;
    song_sel = 2'd2;
    @(posedge clk); #1;
    state = 2'd2;
    @(posedge clk); #1;
    n_checks++;
    if (rom_req !== 1'b1) begin n_fail++; $display("FAIL play_start_req got %b required 1", rom_req); end
    n_checks++;
    if (rom_addr !== 8'h80) begin n_fail++; $display("FAIL play_start_addr got %h required 80", rom_addr); end
    state = 2'd1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || rom_req !== 1'b0) begin
      n_fail++; $display("FAIL abort_before_ack got busy=%b req=%b required 0 0", busy, rom_req);
    end
  endtask

  task automatic test_chart_playback();
    bit ok;
    rom_mem[8'h40] = 8'h10; rom_mem[8'h41] = 8'h21; rom_mem[8'h42] = 8'h80;
    rom_auto = 1'b1; rom_lat = 2; rdy_rand = 1'b0; rdy_val = 1'b1;
    play_song(2'd1, 200, 1'b0, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL playback_finish got finish=0 required 1 within budget"); end
    n_checks++;
    if (q_spawn.size() != 2 || q_spawn[0] !== 3'b001 || q_spawn[1] !== 3'b010) begin
      n_fail++; $display("FAIL playback_spawns got %p required '{1,2}", q_spawn);
    end
    n_checks++;
    if (q_wait.size() != 2 || q_wait[0] != 8 || q_wait[1] != 16) begin
      n_fail++; $display("FAIL playback_waits got %p required '{8,16}", q_wait);
    end
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (finish !== 1'b1 || step_idx !== 6'd2) begin
      n_fail++; $display("FAIL finish_held got fin=%b step=%0d required 1 2", finish, step_idx);
    end
    end_play();
    n_checks++;
    if (busy !== 1'b0 || finish !== 1'b0) begin
      n_fail++; $display("FAIL leave_done got busy=%b fin=%b required 0 0", busy, finish);
    end
    state = 2'd1;
  endtask

  task automatic test_rest_only();
    bit ok;
    rom_mem[8'h80] = 8'h05; rom_mem[8'h81] = 8'h80;
    play_song(2'd2, 200, 1'b0, ok);
    n_checks++;
    if (!ok || q_spawn.size() != 0) begin
      n_fail++; $display("FAIL rest_only_spawn got ok=%b spawns=%0d required 1 0", ok, q_spawn.size());
    end
    n_checks++;
    if (q_wait.size() != 1 || q_wait[0] != 48) begin
      n_fail++; $display("FAIL rest_only_wait got %p required '{48}", q_wait);
    end
    n_checks++;
    if (step_idx !== 6'd1 || q_fetch.size() != 2 || q_fetch[1] !== 8'h81) begin
      n_fail++; $display("FAIL rest_only_step got step=%0d fetches=%p required 1 '{128,129}", step_idx, q_fetch);
    end
    end_play();
    state = 2'd1;
  endtask

  task automatic test_back_pressure();
    bit seen = 1'b0;
    int stable = 0;
    bit ok = 1'b0;
    rom_mem[8'hC0] = 8'h30; rom_mem[8'hC1] = 8'h80;
    rdy_val = 1'b0;
    clear_mon();
    song_sel = 2'd3;
    @(posedge clk); #1;
    state = 2'd2;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (spawn_valid) begin seen = 1'b1; break; end
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL bp_valid got spawn_valid=0 required 1 within 20 cycles"); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (spawn_valid === 1'b1 && spawn_lanes === 3'b011) stable++;
    end
    n_checks++;
    if (stable != 10) begin n_fail++; $display("FAIL bp_stable got %0d stable cycles required 10", stable); end
    rdy_val = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (finish) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok || q_spawn.size() != 1 || stab_viol != 0) begin
      n_fail++; $display("FAIL bp_transfer got ok=%b transfers=%0d viol=%0d required 1 1 0", ok, q_spawn.size(), stab_viol);
    end
    n_checks++;
    if (q_wait.size() != 1 || q_wait[0] != 8) begin
      n_fail++; $display("FAIL bp_wait got %p required '{8}", q_wait);
    end
    end_play();
    state = 2'd1;
  endtask

  task automatic test_abort();
    bit got = 1'b0;
    bit ok;
    rom_lat = 3;
    clear_mon();
    song_sel = 2'd1;
    @(posedge clk); #1;
    state = 2'd2;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rom_ack) begin got = 1'b1; break; end
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL abort_ack got no rom_ack required ack within 20 cycles"); end
    state = 2'd1;
    @(posedge clk); #1;
    n_checks++;
    if (rom_req !== 1'b0 || busy !== 1'b0 || spawn_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle got req=%b busy=%b sv=%b required 0 0 0", rom_req, busy, spawn_valid);
    end
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (fin_seen || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_no_finish got fin_seen=%b busy=%b required 0 0", fin_seen, busy);
    end
    rom_lat = 2;
    play_song(2'd1, 200, 1'b0, ok);
    n_checks++;
    if (!ok || q_fetch.size() == 0 || q_fetch[0] !== 8'h40 || q_spawn.size() != 2) begin
      n_fail++; $display("FAIL abort_refetch got ok=%b fetches=%p spawns=%0d required 1 first 64 2", ok, q_fetch, q_spawn.size());
    end
    end_play();
    state = 2'd1;
  endtask

  task automatic test_song0();
    bit found = 1'b0;
    clear_mon();
    song_sel = 2'd0;
    @(posedge clk); #1;
    state = 2'd2;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (finish) found = 1'b1;
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL song0_finish got finish=0 required 1 within 2 cycles"); end
    n_checks++;
    if (req_starts != 0) begin n_fail++; $display("FAIL song0_no_req got %0d requests required 0", req_starts); end
    end_play();
    state = 2'd1;
  endtask

  task automatic test_async_reset();
    bit in_wait = 1'b0;
    rom_mem[8'h80] = 8'h0F; rom_mem[8'h81] = 8'h80;
    song_sel = 2'd2;
    @(posedge clk); #1;
    state = 2'd2;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy && !rom_req && !spawn_valid) begin in_wait = 1'b1; break; end
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (!in_wait || {rom_req, rom_addr, spawn_valid, finish, step_idx, busy} !== '0) begin
      n_fail++; $display("FAIL async_reset got in_wait=%b busy=%b addr=%h required 1 0 00", in_wait, busy, rom_addr);
    end
    state = 2'd1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_idle got busy=%b required 0", busy); end
  endtask

  task automatic test_random();
    bit ok;
    logic [1:0] s;
    int len;
    for (int it = 0; it < 4; it++) begin
      s = 2'($urandom_range(1, 3));
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) rom_mem[{s, 6'(k)}] = {1'b0, 3'($urandom), 4'($urandom_range(0, 3))};
      rom_mem[{s, 6'(len)}] = 8'h80 | 8'($urandom);
      rom_lat = $urandom_range(1, 4);
      rdy_rand = 1'b1;
      model_song(s);
      play_song(s, 2000, 1'b1, ok);
      n_checks++;
      if (!ok || q_fetch.size() != exp_fetch.size() || q_spawn.size() != exp_spawn.size() || q_wait.size() != exp_wait.size()) begin
        n_fail++; $display("FAIL rand_counts it=%0d got ok=%b f=%0d s=%0d w=%0d required 1 %0d %0d %0d", it, ok,
                           q_fetch.size(), q_spawn.size(), q_wait.size(), exp_fetch.size(), exp_spawn.size(), exp_wait.size());
      end
      foreach (exp_fetch[i]) if (i < int'(q_fetch.size())) begin
        n_checks++;
        if (q_fetch[i] !== exp_fetch[i]) begin n_fail++; $display("FAIL rand_fetch[%0d] got %h required %h", i, q_fetch[i], exp_fetch[i]); end
      end
      foreach (exp_spawn[i]) if (i < int'(q_spawn.size())) begin
        n_checks++;
        if (q_spawn[i] !== exp_spawn[i]) begin n_fail++; $display("FAIL rand_spawn[%0d] got %b required %b", i, q_spawn[i], exp_spawn[i]); end
      end
      foreach (exp_wait[i]) if (i < int'(q_wait.size())) begin
        n_checks++;
        if (q_wait[i] != exp_wait[i]) begin n_fail++; $display("FAIL rand_wait[%0d] got %0d required %0d", i, q_wait[i], exp_wait[i]); end
      end
      n_checks++;
      if (step_idx !== 6'(exp_last) || stab_viol != 0) begin
        n_fail++; $display("FAIL rand_step got step=%0d viol=%0d required %0d 0", step_idx, stab_viol, exp_last);
      end
      end_play();
      state = 2'd1;
    end
    rdy_rand = 1'b0;
  endtask

  task automatic test_implicit_end();
    bit ok;
    for (int k = 0; k < 64; k++) rom_mem[{2'd3, 6'(k)}] = {1'b0, 3'($urandom), 4'd0};
    rom_lat = 1; rdy_val = 1'b1;
    model_song(2'd3);
    play_song(2'd3, 2000, 1'b0, ok);
    n_checks++;
    if (!ok || step_idx !== 6'd63 || q_fetch.size() != 64) begin
      n_fail++; $display("FAIL implicit_end got ok=%b step=%0d fetches=%0d required 1 63 64", ok, step_idx, q_fetch.size());
    end
    n_checks++;
    if (q_spawn.size() != exp_spawn.size() || q_wait.size() != exp_wait.size()) begin
      n_fail++; $display("FAIL implicit_counts got s=%0d w=%0d required %0d %0d", q_spawn.size(), q_wait.size(), exp_spawn.size(), exp_wait.size());
    end
    foreach (exp_spawn[i]) if (i < int'(q_spawn.size())) begin
      n_checks++;
      if (q_spawn[i] !== exp_spawn[i]) begin n_fail++; $display("FAIL implicit_spawn[%0d] got %b required %b", i, q_spawn[i], exp_spawn[i]); end
    end
    foreach (exp_wait[i]) if (i < int'(q_wait.size())) begin
      n_checks++;
      if (q_wait[i] != exp_wait[i]) begin n_fail++; $display("FAIL implicit_wait[%0d] got %0d required %0d", i, q_wait[i], exp_wait[i]); end
    end
    end_play();
    state = 2'd1;
  endtask

`ifdef CHART_PAUSE_EN
  task automatic test_pause();
    bit in_wait = 1'b0;
    bit ok = 1'b0;
    rom_mem[8'h40] = 8'h11; rom_mem[8'h41] = 8'h80;
    rom_lat = 2;
    clear_mon();
    song_sel = 2'd1;
    @(posedge clk); #1;
    state = 2'd2;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy && !rom_req && !spawn_valid && !finish) begin in_wait = 1'b1; break; end
    end
    pause = 1'b1;
    repeat (20) @(negedge clk);
    pause = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (finish) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!in_wait || !ok || q_wait.size() != 1 || q_wait[0] != 2 * BEAT_CYC + 20) begin
      n_fail++; $display("FAIL pause_extend got in_wait=%b ok=%b waits=%p required 1 1 '{36}", in_wait, ok, q_wait);
    end
    end_play();
    state = 2'd1;
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'h80;
    test_reset();
    test_chart_playback();
    test_rest_only();
    test_back_pressure();
    test_abort();
    test_song0();
    test_async_reset();
    test_random();
    test_implicit_end();
`ifdef CHART_PAUSE_EN
    test_pause();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
